// File: rtl/relay_frame_detector.sv
// Relay framing engine: decimates the serial relay input, tracks start/end patterns in a
// shift history and steers the ISO14443-A front end between listen and modulate codes.
module relay_frame_detector #(
  parameter int DIV_LOG2     = 4,
  parameter int SAMPLE_PHASE = 8,
  parameter int START_W      = 8,
  parameter int END_W        = 16,
  parameter int BYTE_W       = 8,
  parameter int MAX_BYTES    = 64,
  parameter int DELAY_TAP    = 7
) (
  input  logic               ck_1356meg,
  input  logic               nrst,
  input  logic [2:0]         cfg_mod_type,
  input  logic               relay_in,
  input  logic               ssp_dout,
  input  logic [START_W-1:0] start_pat,
  input  logic [END_W-1:0]   end_pat_a,
  input  logic [END_W-1:0]   end_pat_b,
  input  logic [END_W-1:0]   end_mask,
  output logic [2:0]         mod_type,
  output logic               relay_data,
  output logic               sample_strobe,
  output logic               in_frame,
  output logic               frame_start,
  output logic               frame_end,
  output logic               frame_timeout
);

  localparam int HIST_W  = START_W + END_W;
  localparam int BC_W    = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
  localparam int BYTES_W = (MAX_BYTES > 0) ? $clog2(MAX_BYTES + 1) : 1;

  localparam logic [2:0] FAKE_READER   = 3'b101;
  localparam logic [2:0] FAKE_TAG      = 3'b110;
  localparam logic [2:0] TAGSIM_LISTEN = 3'b001;
  localparam logic [2:0] TAGSIM_MOD    = 3'b010;
  localparam logic [2:0] READER_LISTEN = 3'b011;
  localparam logic [2:0] READER_MOD    = 3'b100;

  localparam logic [DIV_LOG2-1:0] PHASE      = DIV_LOG2'(SAMPLE_PHASE);
  localparam logic [BC_W-1:0]     BC_LAST    = BC_W'(BYTE_W - 1);
  localparam logic [BC_W-1:0]     BC_ZERO    = {BC_W{1'b0}};
  localparam logic [BYTES_W-1:0]  BYTES_LAST = BYTES_W'(MAX_BYTES - 1);
  localparam logic [BYTES_W-1:0]  BYTES_SAT  = {BYTES_W{1'b1}};

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  logic [DIV_LOG2-1:0] div_r;
  logic [HIST_W-1:0]   hist_r;
  logic [BC_W-1:0]     bc_r;
  logic [BYTES_W-1:0]  bytes_r;
  state_t              state_r;
  logic [2:0]          cfg_prev_r;
  logic                sample_strobe_r;
  logic                frame_start_r;
  logic                frame_end_r;
  logic                frame_timeout_r;

  logic                strobe_s;
  logic                relay_s;
  logic                prev_relay_s;
  logic                clear_s;
  logic [HIST_W-1:0]   hist_n_s;
  logic [BC_W-1:0]     bc_n_s;
  logic [END_W-1:0]    end_field_s;
  logic                start_match_s;
  logic                end_match_s;
  logic                timeout_s;

  // Free-running sample divider, independent of relay mode.
  always_ff @(posedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      div_r <= {DIV_LOG2{1'b0}};
    end else begin
      div_r <= div_r + 1'b1;
    end
  end

  // Next-sample history, alignment count and pattern matches.
  always_comb begin
    strobe_s      = (div_r == PHASE);
    relay_s       = (cfg_mod_type == FAKE_READER) || (cfg_mod_type == FAKE_TAG);
    prev_relay_s  = (cfg_prev_r == FAKE_READER) || (cfg_prev_r == FAKE_TAG);
    // A hop between the two relay modes restarts framing just like leaving relay mode.
    clear_s       = !relay_s || (prev_relay_s && (cfg_mod_type != cfg_prev_r));
    hist_n_s      = {hist_r[HIST_W-2:0], relay_in};
    bc_n_s        = (bc_r == BC_LAST) ? BC_ZERO : (bc_r + 1'b1);
    end_field_s   = hist_n_s[HIST_W-1:START_W];
    start_match_s = (hist_n_s[START_W-1:0] == start_pat);
    end_match_s   = ((((end_field_s ^ end_pat_a) & end_mask) == {END_W{1'b0}}) ||
                     (((end_field_s ^ end_pat_b) & end_mask) == {END_W{1'b0}})) &&
                    (bc_n_s == BC_LAST);
    timeout_s     = (MAX_BYTES != 0) && (bc_n_s == BC_ZERO) && (bytes_r == BYTES_LAST);
  end

  // Framing FSM with history, counters and event pulses.
  always_ff @(posedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      hist_r          <= {HIST_W{1'b0}};
      bc_r            <= BC_ZERO;
      bytes_r         <= {BYTES_W{1'b0}};
      state_r         <= IDLE;
      cfg_prev_r      <= 3'b000;
      sample_strobe_r <= 1'b0;
      frame_start_r   <= 1'b0;
      frame_end_r     <= 1'b0;
      frame_timeout_r <= 1'b0;
    end else begin
      sample_strobe_r <= strobe_s;
      cfg_prev_r      <= cfg_mod_type;
      frame_start_r   <= 1'b0;
      frame_end_r     <= 1'b0;
      frame_timeout_r <= 1'b0;
      if (clear_s) begin
        hist_r  <= {HIST_W{1'b0}};
        bc_r    <= BC_ZERO;
        bytes_r <= {BYTES_W{1'b0}};
        state_r <= IDLE;
      end else if (strobe_s) begin
        hist_r <= hist_n_s;
        bc_r   <= bc_n_s;
        if (start_match_s) begin
          state_r       <= ACTIVE;
          bc_r          <= BC_ZERO;
          bytes_r       <= {BYTES_W{1'b0}};
          frame_start_r <= 1'b1;
        end else if ((state_r == ACTIVE) && end_match_s) begin
          state_r     <= IDLE;
          frame_end_r <= 1'b1;
        end else if ((state_r == ACTIVE) && timeout_s) begin
          state_r         <= IDLE;
          frame_timeout_r <= 1'b1;
        end else if ((state_r == ACTIVE) && (bc_n_s == BC_ZERO) && (bytes_r != BYTES_SAT)) begin
          bytes_r <= bytes_r + 1'b1;
        end
      end
    end
  end

  // Front-end code and data mux; passthrough outside relay mode.
  always_comb begin
    mod_type   = cfg_mod_type;
    relay_data = ssp_dout;
    case (cfg_mod_type)
      FAKE_READER: begin
        mod_type   = (state_r == ACTIVE) ? TAGSIM_MOD : TAGSIM_LISTEN;
        relay_data = hist_r[DELAY_TAP];
      end
      FAKE_TAG: begin
        mod_type   = (state_r == ACTIVE) ? READER_MOD : READER_LISTEN;
        relay_data = hist_r[DELAY_TAP];
      end
      default: begin
        mod_type   = cfg_mod_type;
        relay_data = ssp_dout;
      end
    endcase
  end

  assign sample_strobe = sample_strobe_r;
  assign in_frame      = (state_r == ACTIVE);
  assign frame_start   = frame_start_r;
  assign frame_end     = frame_end_r;
  assign frame_timeout = frame_timeout_r;

endmodule

// File: tb/tb_relay_frame_detector.sv
// Bench for relay_frame_detector: a sample-queue reference model checked every clock,
// directed framing scenarios with hand-derived expectations, then randomized traffic.
module tb_relay_frame_detector;

  localparam int DIV_LOG2     = 4;
  localparam int SAMPLE_PHASE = 8;
  localparam int START_W      = 8;
  localparam int END_W        = 16;
  localparam int BYTE_W       = 8;
  localparam int MAX_BYTES    = 4;
  localparam int DELAY_TAP    = 7;
  localparam int DIV_N        = 1 << DIV_LOG2;
  localparam int HIST_W       = START_W + END_W;

  logic         ck_1356meg = 1'b0;
  logic         nrst = 1'b0;
  logic [2:0]   cfg_mod_type = 3'b000;
  logic         relay_in = 1'b0;
  logic         ssp_dout = 1'b0;
  logic [7:0]   start_pat = 8'h00;
  logic [15:0]  end_pat_a = 16'h0000;
  logic [15:0]  end_pat_b = 16'h0000;
  logic [15:0]  end_mask = 16'h0000;
  logic [2:0]   mod_type;
  logic         relay_data, sample_strobe, in_frame, frame_start, frame_end, frame_timeout;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  relay_frame_detector #(
    .DIV_LOG2(DIV_LOG2), .SAMPLE_PHASE(SAMPLE_PHASE), .START_W(START_W), .END_W(END_W),
    .BYTE_W(BYTE_W), .MAX_BYTES(MAX_BYTES), .DELAY_TAP(DELAY_TAP)
  ) dut (
    .ck_1356meg(ck_1356meg), .nrst(nrst), .cfg_mod_type(cfg_mod_type), .relay_in(relay_in),
    .ssp_dout(ssp_dout), .start_pat(start_pat), .end_pat_a(end_pat_a), .end_pat_b(end_pat_b),
    .end_mask(end_mask), .mod_type(mod_type), .relay_data(relay_data),
    .sample_strobe(sample_strobe), .in_frame(in_frame), .frame_start(frame_start),
    .frame_end(frame_end), .frame_timeout(frame_timeout)
  );

  always #5 ck_1356meg = ~ck_1356meg;

  // ---------------- reference model: list of samples since the last clear ----------------
  int         m_div = 0;
  logic [2:0] m_prev_cfg = 3'b000;
  bit         m_q[$];
  int         m_since = 0;
  bit         m_active = 1'b0;
  bit         exp_strobe = 1'b0, exp_fs = 1'b0, exp_fe = 1'b0, exp_ft = 1'b0;
  bit         m_strobe_now, m_clear, m_start, m_end;
  int         m_n;

  function automatic bit is_relay(input logic [2:0] c);
    return (c == 3'b101) || (c == 3'b110);
  endfunction

  function automatic bit hist_bit(input int i);
    if (i < m_q.size()) return m_q[m_q.size() - 1 - i];
    return 1'b0;
  endfunction

  function automatic bit start_hit();
    for (int j = 0; j < START_W; j++) if (hist_bit(j) != start_pat[j]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit end_hit(input logic [15:0] pat);
    for (int k = 0; k < END_W; k++)
      if (end_mask[k] && (hist_bit(START_W + k) != pat[k])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [2:0] exp_mod();
    if (cfg_mod_type == 3'b101) return m_active ? 3'b010 : 3'b001;
    if (cfg_mod_type == 3'b110) return m_active ? 3'b100 : 3'b011;
    return cfg_mod_type;
  endfunction

  initial forever begin
    @(posedge ck_1356meg or negedge nrst);
    if (!nrst) begin
      m_div = 0; m_prev_cfg = 3'b000; m_q.delete(); m_since = 0; m_active = 1'b0;
      exp_strobe = 1'b0; exp_fs = 1'b0; exp_fe = 1'b0; exp_ft = 1'b0;
    end else begin
      m_strobe_now = (m_div == SAMPLE_PHASE);
      m_div = (m_div + 1) % DIV_N;
      exp_strobe = m_strobe_now;
      exp_fs = 1'b0; exp_fe = 1'b0; exp_ft = 1'b0;
      m_clear = !is_relay(cfg_mod_type) || (is_relay(m_prev_cfg) && (cfg_mod_type != m_prev_cfg));
      m_prev_cfg = cfg_mod_type;
      if (m_clear) begin
        m_q.delete(); m_since = 0; m_active = 1'b0;
      end else if (m_strobe_now) begin
        m_q.push_back(relay_in);
        if (m_q.size() > HIST_W) void'(m_q.pop_front());
        m_n = m_since + 1;
        m_start = start_hit();
        m_end = (end_hit(end_pat_a) || end_hit(end_pat_b)) && (m_n % BYTE_W == BYTE_W - 1);
        if (m_start) begin
          m_active = 1'b1; m_since = 0; exp_fs = 1'b1;
        end else if (m_active && m_end) begin
          m_active = 1'b0; exp_fe = 1'b1; m_since = m_n;
        end else if (m_active && (m_n == MAX_BYTES * BYTE_W)) begin
          m_active = 1'b0; exp_ft = 1'b1; m_since = m_n;
        end else begin
          m_since = m_n;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge ck_1356meg);
    if (chk_en) begin
      if (is_relay(cfg_mod_type)) chk("sample_strobe", 32'(sample_strobe), 32'(exp_strobe));
      chk("in_frame", 32'(in_frame), 32'(m_active));
      chk("frame_start", 32'(frame_start), 32'(exp_fs));
      chk("frame_end", 32'(frame_end), 32'(exp_fe));
      chk("frame_timeout", 32'(frame_timeout), 32'(exp_ft));
      chk("mod_type", 32'(mod_type), 32'(exp_mod()));
      chk("relay_data", 32'(relay_data),
          32'(is_relay(cfg_mod_type) ? hist_bit(DELAY_TAP) : ssp_dout));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clk_wait(input int n);
    repeat (n) begin @(posedge ck_1356meg); #1; ssp_dout = 1'($urandom_range(0, 1)); end
  endtask

  task automatic send_bit(input logic b);
    bit got;
    got = 1'b0;
    relay_in = b;
    for (int i = 0; i < 2 * DIV_N + 8 && !got; i++) begin
      @(posedge ck_1356meg); #1;
      ssp_dout = 1'($urandom_range(0, 1));
      if (exp_strobe) got = 1'b1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL send_bit: sample strobe missing");
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic restart_relay(input logic [2:0] cfg);
    cfg_mod_type = 3'b000;
    clk_wait(2);
  endtask

  initial begin
    int c1, c2, k;
    bit seen;
    logic [31:0] aa;
    logic [7:0] rm;
    clk_wait(3);
    chk_en = 1'b1;
    chk("rst_in_frame", 32'(in_frame), 32'(0));
    chk("rst_pulses", 32'({frame_start, frame_end, frame_timeout}), 32'(0));
    chk("rst_mod_type", 32'(mod_type), 32'(0));
    nrst = 1'b1;
    clk_wait(2);

    // passthrough
    ssp_dout = 1'b1; #1 chk("pass_data_1", 32'(relay_data), 32'(1));
    ssp_dout = 1'b0; #1 chk("pass_data_0", 32'(relay_data), 32'(0));
    chk("pass_mod", 32'(mod_type), 32'(3'b000));
    cfg_mod_type = 3'b101; #1 chk("reader_idle_mod", 32'(mod_type), 32'(3'b001));

    // strobe period
    c1 = -1; c2 = -1;
    for (int i = 0; i < 60 && c2 < 0; i++) begin
      @(posedge ck_1356meg); #1;
      if (sample_strobe) begin
        if (c1 < 0) c1 = i; else c2 = i;
      end
    end
    chk("strobe_period", 32'(c2 - c1), 32'(16));

    // FAKE_READER start on 0xC0, end on zeros aligned to bit count 7
    start_pat = 8'hC0; end_pat_a = 16'h0000; end_pat_b = 16'hC000; end_mask = 16'hFFFF;
    for (int i = 7; i >= 0; i--) begin
      send_bit(start_pat[i]);
      chk("c0_start_pulse", 32'(frame_start), 32'(i == 0));
    end
    chk("c0_in_frame", 32'(in_frame), 32'(1));
    chk("c0_mod", 32'(mod_type), 32'(3'b010));
    chk("model_active", 32'(m_active), 32'(1));
    k = 0; seen = 1'b0;
    while (k < 30 && !seen) begin
      send_bit(1'b0); k++;
      if (frame_end) seen = 1'b1;
    end
    chk("zeros_to_end", 32'(k), 32'(23));
    chk("end_mod", 32'(mod_type), 32'(3'b001));

    // FAKE_TAG with masked end
    cfg_mod_type = 3'b110; clk_wait(2);
    start_pat = 8'hF0; end_pat_a = 16'h0000; end_pat_b = 16'h00FF; end_mask = 16'h00FF;
    send_byte(8'hF0);
    chk("tag_start_mod", 32'(mod_type), 32'(3'b100));
    k = 0; seen = 1'b0;
    while (k < 30 && !seen) begin
      send_bit(1'b0); k++;
      if (frame_end) seen = 1'b1;
    end
    chk("tag_zeros_to_end", 32'(k), 32'(15));
    chk("tag_end_mod", 32'(mod_type), 32'(3'b011));

    // timeout after 4 bytes of 0xAA
    restart_relay(3'b000);
    start_pat = 8'hC0; end_pat_a = 16'h0000; end_pat_b = 16'hFFFF; end_mask = 16'hFFFF;
    cfg_mod_type = 3'b101;
    send_byte(8'hC0);
    chk("to_start", 32'(frame_start), 32'(1));
    for (int j = 1; j <= 32; j++) begin
      send_bit(j % 2);
      chk("timeout_at_32", 32'(frame_timeout), 32'(j == 32));
    end
    chk("to_idle", 32'(in_frame), 32'(0));

    // re-match at sample 20 restarts the byte count
    restart_relay(3'b000);
    cfg_mod_type = 3'b101;
    send_byte(8'hC0);
    rm = 8'hC0;
    for (int j = 1; j <= 56; j++) begin
      if (j >= 13 && j <= 20) send_bit(rm[20 - j]);
      else send_bit(j % 2);
      chk("rematch_start", 32'(frame_start), 32'(j == 20));
      chk("rematch_timeout", 32'(frame_timeout), 32'(j == 52));
    end

    // simultaneous start and end: start wins
    restart_relay(3'b000);
    start_pat = 8'h81; end_mask = 16'h0000;
    cfg_mod_type = 3'b101;
    send_byte(8'h81);
    chk("sim_first_start", 32'(frame_start), 32'(1));
    for (int j = 6; j >= 0; j--) send_bit(j == 0);
    chk("sim_start", 32'(frame_start), 32'(1));
    chk("sim_no_end", 32'(frame_end), 32'(0));
    chk("sim_active", 32'(in_frame), 32'(1));

    // asynchronous reset mid-frame
    @(posedge ck_1356meg); #4;
    nrst = 1'b0; #1;
    chk("arst_in_frame", 32'(in_frame), 32'(0));
    chk("arst_mod", 32'(mod_type), 32'(3'b001));
    chk("arst_pulses", 32'({frame_start, frame_end, frame_timeout}), 32'(0));
    @(negedge ck_1356meg); nrst = 1'b1;
    clk_wait(2);

    // randomized traffic
    for (int r = 0; r < 24; r++) begin
      if ($urandom_range(0, 2) == 0 && is_relay(cfg_mod_type))
        cfg_mod_type = (cfg_mod_type == 3'b101) ? 3'b110 : 3'b101;
      else
        cfg_mod_type = 3'b000;
      clk_wait(2);
      start_pat = 8'($urandom);
      end_pat_a = 16'($urandom); end_pat_b = 16'($urandom);
      end_mask = 16'($urandom & $urandom & $urandom);
      if (cfg_mod_type == 3'b000) cfg_mod_type = $urandom_range(0, 1) ? 3'b101 : 3'b110;
      for (int s = 0; s < 40; s++) begin
        if ($urandom_range(0, 5) == 0) send_byte(start_pat);
        else send_bit(1'($urandom_range(0, 1)));
      end
    end

    clk_wait(2);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/relay_frame_detector.md
# relay_frame_detector

Parametrised framing engine for the 13.56 MHz relay path. It decimates the serial relay input (`dbg`) to a bit-sample rate and shifts the samples into a history register. It detects configurable start and end patterns and drives the `mod_type` code into the ISO14443-A front end, so the front end switches between listen and modulate phases as a fake reader or fake tag. It replaces the fixed-pattern detector in the top level, adding runtime-programmable patterns, masked end matching, a frame-length timeout, a selectable output delay tap and status pulses.

## Interface
- `DIV_LOG2`, 4: sample divider is 2^DIV_LOG2 clocks (default 16, about 847.5 kHz).
- `SAMPLE_PHASE`, 8: divider value on which a sample is taken (0 to 2^DIV_LOG2-1).
- `START_W`, 8: start pattern width.
- `END_W`, 16: end pattern width; the history depth is `START_W+END_W` (default 24).
- `BYTE_W`, 8: alignment period for end detection, in samples.
- `MAX_BYTES`, 64: whole bytes allowed in a frame before timeout; 0 disables the timeout.
- `DELAY_TAP`, 7: history index driven to `relay_data`, in the range 0 to `START_W+END_W-1`.

Ports:
- `ck_1356meg` in 1: the only clock; all flops are on its rising edge.
- `nrst` in 1: asynchronous, active-low reset.
- `cfg_mod_type` in 3: `conf_word[2:0]`. Relay mode is active when this is 3'b101 (FAKE_READER) or 3'b110 (FAKE_TAG).
- `relay_in` in 1: raw serial relay input (`dbg`), already synchronised externally.
- `ssp_dout` in 1: ARM serial data, passed through when not in relay mode.
- `start_pat` in START_W: start pattern.
- `end_pat_a`, `end_pat_b` in END_W each: two alternative end patterns.
- `end_mask` in END_W: 1 = bit compared, 0 = don't care.
- `mod_type` out 3: modulation code to `hi_iso14443a`.
- `relay_data` out 1: data to the front end's `ssp_dout` input.
- `sample_strobe` out 1: one-clock pulse on each sample.
- `in_frame` out 1: high while the state is ACTIVE.
- `frame_start`, `frame_end`, `frame_timeout` out 1 each: one-clock event pulses.

## Operation
- The divider is a free-running DIV_LOG2-bit counter, also outside relay mode. `strobe` is true when the counter equals `SAMPLE_PHASE`.
- When not in relay mode:
  - history, bit counter and byte counter are held at 0, and the state is IDLE;
  - `mod_type = cfg_mod_type` and `relay_data = ssp_dout`.
- When in relay mode, on each strobe:
  - `hist_n = {hist[W-2:0], relay_in}`, where `W = START_W+END_W`;
  - `bc_n = (bc == BYTE_W-1) ? 0 : bc+1`.
- Start match: `hist_n[START_W-1:0] == start_pat`.
- End match: `((hist_n[W-1:START_W] ^ end_pat_a) & end_mask) == 0`, or the same test with `end_pat_b`, and `bc_n == BYTE_W-1`.
- Priority on a strobe, highest first:
  1. Start match, evaluated in either state: state becomes ACTIVE, `bc` and the byte counter clear to 0, and `frame_start` pulses. This also re-synchronises an ACTIVE frame.
  2. ACTIVE and end match: state becomes IDLE and `frame_end` pulses.
  3. ACTIVE, `MAX_BYTES != 0`, `bc_n == 0`, and the byte counter reaches `MAX_BYTES`: state becomes IDLE and `frame_timeout` pulses.
  4. Otherwise the history and counters update and the state is unchanged.
- The byte counter increments when `bc_n == 0` while ACTIVE. It saturates and never wraps.
- `mod_type` in relay mode:
  - FAKE_READER: ACTIVE gives 3'b010 (TAGSIM_MOD), IDLE gives 3'b001 (TAGSIM_LISTEN).
  - FAKE_TAG: ACTIVE gives 3'b100 (READER_MOD), IDLE gives 3'b011 (READER_LISTEN).
- `relay_data = hist[DELAY_TAP]` in relay mode.
- Leaving relay mode, or switching between FAKE_READER and FAKE_TAG, clears the history and counters and forces IDLE on the next clock edge. No event pulses are generated by this.
- Patterns and mask are sampled on every strobe. Software changes them only while IDLE.

## Timing
- Reset values: divider 0, history 0, `bc` 0, byte counter 0, state IDLE, all pulses 0, `in_frame` 0.
- After reset, `mod_type` and `relay_data` follow the combinational mux of `cfg_mod_type` and `ssp_dout`. In relay mode they give the IDLE code and `hist[DELAY_TAP] = 0`.
- Reset asserted mid-frame returns to IDLE immediately and asynchronously; no end or timeout pulse is generated.
- `sample_strobe` and the state, history and event pulses are registered. They all change on the same edge as the sampled strobe, one clock after the divider reaches `SAMPLE_PHASE`.
- `mod_type` and `relay_data` are combinational from registered state and the config/passthrough inputs, with zero added latency.
- From the last pattern bit presented on `relay_in` to the `mod_type` change: at most 2^DIV_LOG2 clocks plus 1 clock.

## Test plan
- Reset, then `cfg_mod_type=3'b000` and `ssp_dout` toggling: `mod_type=000` and `relay_data` follows `ssp_dout`. Then `cfg=3'b101`: `mod_type=001`, and `sample_strobe` has a period of 16 clocks.
- FAKE_READER with `start_pat=8'hC0`: shift in 1,1,0,0,0,0,0,0. On the 8th strobe `frame_start` pulses, `in_frame` goes to 1 and `mod_type=010`. Each `relay_data` bit equals the input from 8 strobes earlier.
- FAKE_READER with `end_pat_a=16'h0000`, `end_pat_b=16'hC000`, `end_mask=16'hFFFF`, after a start: 16 zeros with the alignment bit count equal to 7 cause `frame_end` and `mod_type=001`. The same zeros at bit count 3 cause no end.
- FAKE_TAG with `start_pat=8'hF0`, `end_pat_a=16'h0000`, `end_mask=16'h00FF`: on the start, `mod_type=100`; 8 zero bits aligned to the byte end cause `mod_type=011`.
- With `MAX_BYTES=4`, a start followed by 32 non-matching samples (0xAA pattern) gives `frame_timeout` exactly on the 32nd strobe and the state returns to IDLE. A start re-match at sample 20 instead restarts the count.
- Simultaneous start and end match on one strobe: only `frame_start` pulses and the state stays ACTIVE. `nrst` pulsed mid-frame gives IDLE immediately, with no pulses.
